multi_zone_thermostat: RTL and testbench

Per-zone heat/cool controller for N independent zones sharing one setpoint, hysteresis margin and operating mode. Each zone runs its own FSM, with minimum-run and minimum-rest timers that protect compressor and boiler equipment. It sits between the sensor-sampling front end and the HVAC actuator drivers. Temperature inputs are only evaluated on sample strobes.

---
 rtl/multi_zone_thermostat_if.sv | 28 ++
 rtl/multi_zone_thermostat.sv | 114 +++++++++++
 tb/tb_multi_zone_thermostat.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_zone_thermostat_if.sv
// Bundle between the sensor front end, the thermostat core and the actuator drivers.
// master drives samples and configuration; slave (the core) returns per-zone demand.
interface multi_zone_thermostat_if #(
  parameter int unsigned N_ZONES = 4,
  parameter int unsigned TEMP_W  = 8
);
  localparam int unsigned CntW = $clog2(N_ZONES + 1);

  logic                      sample_valid;
  logic [N_ZONES*TEMP_W-1:0] zone_temp;
  logic [TEMP_W-1:0]         set_temp;
  logic [TEMP_W-1:0]         margin;
  logic [1:0]                mode;
  logic [N_ZONES-1:0]        heating;
  logic [N_ZONES-1:0]        cooling;
  logic [N_ZONES-1:0]        resting;
  logic [CntW-1:0]           active_count;

  modport master (
    output sample_valid, zone_temp, set_temp, margin, mode,
    input  heating, cooling, resting, active_count
  );

  modport slave (
    input  sample_valid, zone_temp, set_temp, margin, mode,
    output heating, cooling, resting, active_count
  );
endinterface

// File: rtl/multi_zone_thermostat.sv
// Per-zone heat/cool controller: one IDLE/HEATING/COOLING/REST FSM per zone, sharing
// setpoint, hysteresis margin and mode, with minimum-run and minimum-rest timers.
module multi_zone_thermostat #(
  parameter int unsigned N_ZONES = 4,
  parameter int unsigned TEMP_W  = 8,
  parameter int unsigned MIN_ON  = 16,
  parameter int unsigned MIN_OFF = 16
) (
  input logic                    clk,
  input logic                    reset,
  multi_zone_thermostat_if.slave bus
);
  localparam int unsigned MaxT = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int unsigned TmrW = (MaxT > 1) ? $clog2(MaxT) : 1;
  localparam int unsigned CntW = $clog2(N_ZONES + 1);

  localparam logic [TmrW-1:0]   OnLoad  = TmrW'(MIN_ON - 1);
  localparam logic [TmrW-1:0]   OffLoad = TmrW'(MIN_OFF - 1);
  localparam logic [TEMP_W:0]   TempMax = {1'b0, {TEMP_W{1'b1}}};

  typedef enum logic [1:0] {StIdle, StHeat, StCool, StRest} zone_state_e;

  zone_state_e     state_q [N_ZONES];
  zone_state_e     state_d [N_ZONES];
  logic [TmrW-1:0] timer_q [N_ZONES];
  logic [TmrW-1:0] timer_d [N_ZONES];
  logic [CntW-1:0] count_q, count_d;

  logic [TEMP_W:0] temp [N_ZONES];
  logic [TEMP_W:0] set_ext, margin_ext, sum, lo, hi;
  logic            heat_ok, cool_ok;

  // Mode bit 0 permits heating, bit 1 permits cooling (AUTO = both).
  assign heat_ok = bus.mode[0];
  assign cool_ok = bus.mode[1];

  always_comb begin
    set_ext    = {1'b0, bus.set_temp};
    margin_ext = {1'b0, bus.margin};
    sum        = set_ext + margin_ext;
    lo         = (bus.set_temp >= bus.margin) ? (set_ext - margin_ext) : '0;
    hi         = (sum > TempMax) ? TempMax : sum;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      temp[i]    = {1'b0, bus.zone_temp[i*TEMP_W +: TEMP_W]};
      state_d[i] = state_q[i];
      timer_d[i] = (timer_q[i] == '0) ? '0 : (timer_q[i] - TmrW'(1));
      unique case (state_q[i])
        StIdle: begin
          if (bus.sample_valid && heat_ok && (temp[i] < lo)) begin
            state_d[i] = StHeat;
            timer_d[i] = OnLoad;
          end else if (bus.sample_valid && cool_ok && (temp[i] > hi)) begin
            state_d[i] = StCool;
            timer_d[i] = OnLoad;
          end
        end
        StHeat: begin
          // Losing permission bypasses the minimum-run timer.
          if (!heat_ok ||
              ((timer_q[i] == '0) && bus.sample_valid && (temp[i] >= set_ext))) begin
            state_d[i] = StRest;
            timer_d[i] = OffLoad;
          end
        end
        StCool: begin
          if (!cool_ok ||
              ((timer_q[i] == '0) && bus.sample_valid && (temp[i] <= set_ext))) begin
            state_d[i] = StRest;
            timer_d[i] = OffLoad;
          end
        end
        StRest: begin
          if (timer_q[i] == '0) begin
            state_d[i] = StIdle;
          end
        end
      endcase
      count_d = count_d + CntW'((state_d[i] == StHeat) || (state_d[i] == StCool));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ZONES; i++) begin
        state_q[i] <= StIdle;
        timer_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < N_ZONES; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    bus.heating = '0;
    bus.cooling = '0;
    bus.resting = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      bus.heating[i] = (state_q[i] == StHeat);
      bus.cooling[i] = (state_q[i] == StCool);
      bus.resting[i] = (state_q[i] == StRest);
    end
  end

  assign bus.active_count = count_q;
endmodule

// File: tb/tb_multi_zone_thermostat.sv
// Bench for multi_zone_thermostat: directed vector table, hand-written corner sequences,
// and randomized stimulus against an age-counting behavioural model.
module tb_multi_zone_thermostat;
  localparam int unsigned NZ   = 4;
  localparam int unsigned TW   = 8;
  localparam int unsigned MON  = 4;
  localparam int unsigned MOFF = 4;

  localparam int MIdle = 0;
  localparam int MHeat = 1;
  localparam int MCool = 2;
  localparam int MRest = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_zone_thermostat_if #(.N_ZONES(NZ), .TEMP_W(TW)) bus ();

  multi_zone_thermostat #(
    .N_ZONES(NZ),
    .TEMP_W (TW),
    .MIN_ON (MON),
    .MIN_OFF(MOFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       sv;
    int         t0, t1, t2, t3;
    int         st, mg;
    logic [1:0] md;
    logic [3:0] eh, ec, er;
    int         en;
  } vec_t;

  vec_t vecs [20];

  int ms  [NZ];
  int age [NZ];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [3:0] eh, input logic [3:0] ec,
                            input logic [3:0] er, input int en);
    check({name, " heating"}, int'(bus.heating), int'(eh));
    check({name, " cooling"}, int'(bus.cooling), int'(ec));
    check({name, " resting"}, int'(bus.resting), int'(er));
    check({name, " active_count"}, int'(bus.active_count), en);
  endtask

  function automatic logic [31:0] pack4(input int t0, input int t1, input int t2, input int t3);
    logic [31:0] p;
    p = {t3[7:0], t2[7:0], t1[7:0], t0[7:0]};
    return p;
  endfunction

  task automatic drive(input logic sv, input logic [31:0] temps, input int st, input int mg,
                       input logic [1:0] md);
    bus.sample_valid = sv;
    bus.zone_temp    = temps;
    bus.set_temp     = st[7:0];
    bus.margin       = mg[7:0];
    bus.mode         = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic model_reset();
    for (int z = 0; z < NZ; z++) begin
      ms[z]  = MIdle;
      age[z] = 0;
    end
  endtask

  // Model counts edges since entering a state; ages reaching MIN_ON/MIN_OFF unlock exit.
  task automatic model_step(input logic sv, input logic [31:0] temps, input int st, input int mg,
                            input logic [1:0] md);
    int lo, hi, t;
    bit hok, cok;
    lo  = st - mg;
    if (lo < 0) lo = 0;
    hi  = st + mg;
    if (hi > 255) hi = 255;
    hok = (md == 2'd1) || (md == 2'd3);
    cok = (md == 2'd2) || (md == 2'd3);
    for (int z = 0; z < NZ; z++) begin
      t = int'(temps[z*8 +: 8]);
      case (ms[z])
        MIdle: begin
          if (sv && hok && t < lo) begin
            ms[z] = MHeat; age[z] = 0;
          end else if (sv && cok && t > hi) begin
            ms[z] = MCool; age[z] = 0;
          end
        end
        MHeat: begin
          age[z]++;
          if (!hok || (age[z] >= MON && sv && t >= st)) begin
            ms[z] = MRest; age[z] = 0;
          end
        end
        MCool: begin
          age[z]++;
          if (!cok || (age[z] >= MON && sv && t <= st)) begin
            ms[z] = MRest; age[z] = 0;
          end
        end
        default: begin
          age[z]++;
          if (age[z] >= MOFF) begin
            ms[z] = MIdle; age[z] = 0;
          end
        end
      endcase
    end
  endtask

  initial begin
    logic [3:0]  eh, ec, er;
    logic [31:0] temps;
    int          st, mg, en, t;
    logic [1:0]  md;
    logic        sv;

    reset = 1'b1;
    drive(1'b0, pack4(20, 20, 20, 20), 20, 2, 2'b11);
    do_reset();
    check_outs("reset", 4'b0000, 4'b0000, 4'b0000, 0);

    // Zone 0 heat cycle with MIN_ON hold and MIN_OFF rest, then threshold edges.
    vecs[0]  = '{1'b1, 17, 20, 20, 20, 20, 2, 2'b11, 4'b0001, 4'b0000, 4'b0000, 1};
    vecs[1]  = '{1'b1, 20, 20, 20, 20, 20, 2, 2'b11, 4'b0001, 4'b0000, 4'b0000, 1};
    vecs[2]  = '{1'b0, 20, 20, 20, 20, 20, 2, 2'b11, 4'b0001, 4'b0000, 4'b0000, 1};
    vecs[3]  = '{1'b0, 20, 20, 20, 20, 20, 2, 2'b11, 4'b0001, 4'b0000, 4'b0000, 1};
    vecs[4]  = '{1'b1, 20, 20, 20, 20, 20, 2, 2'b11, 4'b0000, 4'b0000, 4'b0001, 0};
    vecs[5]  = '{1'b0, 20, 20, 20, 20, 20, 2, 2'b11, 4'b0000, 4'b0000, 4'b0001, 0};
    vecs[6]  = '{1'b0, 20, 20, 20, 20, 20, 2, 2'b11, 4'b0000, 4'b0000, 4'b0001, 0};
    vecs[7]  = '{1'b0, 20, 20, 20, 20, 20, 2, 2'b11, 4'b0000, 4'b0000, 4'b0001, 0};
    vecs[8]  = '{1'b1, 17, 20, 20, 20, 20, 2, 2'b11, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[9]  = '{1'b1, 20, 20, 23, 20, 20, 2, 2'b11, 4'b0000, 4'b0100, 4'b0000, 1};
    vecs[10] = '{1'b1, 18, 22, 23, 20, 20, 2, 2'b11, 4'b0000, 4'b0100, 4'b0000, 1};
    vecs[11] = '{1'b0, 20, 20, 23, 20, 20, 2, 2'b00, 4'b0000, 4'b0000, 4'b0100, 0};
    vecs[12] = '{1'b0, 20, 20, 23, 20, 20, 2, 2'b00, 4'b0000, 4'b0000, 4'b0100, 0};
    vecs[13] = '{1'b0, 20, 20, 23, 20, 20, 2, 2'b00, 4'b0000, 4'b0000, 4'b0100, 0};
    vecs[14] = '{1'b0, 20, 20, 23, 20, 20, 2, 2'b00, 4'b0000, 4'b0000, 4'b0100, 0};
    vecs[15] = '{1'b1, 20, 20, 20, 20, 20, 2, 2'b11, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[16] = '{1'b1, 0, 0, 0, 0, 1, 5, 2'b11, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[17] = '{1'b1, 255, 255, 255, 255, 254, 5, 2'b11, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[18] = '{1'b1, 20, 20, 20, 20, 20, 0, 2'b11, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[19] = '{1'b1, 19, 21, 20, 20, 20, 0, 2'b11, 4'b0001, 4'b0010, 4'b0000, 2};

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].sv, pack4(vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3),
            vecs[i].st, vecs[i].mg, vecs[i].md);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].eh, vecs[i].ec, vecs[i].er, vecs[i].en);
    end

    // Forced exit to OFF at run cycle 1 bypasses MIN_ON; rest still lasts MIN_OFF.
    do_reset();
    drive(1'b1, pack4(17, 20, 20, 20), 20, 2, 2'b11);
    step();
    check_outs("force_enter", 4'b0001, 4'b0000, 4'b0000, 1);
    drive(1'b0, pack4(17, 20, 20, 20), 20, 2, 2'b00);
    step();
    check_outs("force_exit", 4'b0000, 4'b0000, 4'b0001, 0);
    for (int k = 1; k < MOFF; k++) begin
      step();
      check_outs($sformatf("force_rest%0d", k), 4'b0000, 4'b0000, 4'b0001, 0);
    end
    step();
    check_outs("force_idle", 4'b0000, 4'b0000, 4'b0000, 0);

    // HEAT_ONLY never cools.
    drive(1'b1, pack4(30, 30, 20, 20), 20, 2, 2'b01);
    step();
    check_outs("heat_only_hot", 4'b0000, 4'b0000, 4'b0000, 0);

    // All zones trigger on one sample.
    do_reset();
    drive(1'b1, pack4(10, 30, 10, 30), 20, 2, 2'b11);
    step();
    check_outs("all_zones", 4'b0101, 4'b1010, 4'b0000, 4);

    // Async reset between edges clears immediately; re-entry needs no rest.
    drive(1'b0, pack4(10, 30, 10, 30), 20, 2, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_reset", 4'b0000, 4'b0000, 4'b0000, 0);
    #2;
    reset = 1'b0;
    drive(1'b1, pack4(17, 20, 20, 20), 20, 2, 2'b11);
    step();
    check_outs("post_reset_heat", 4'b0001, 4'b0000, 4'b0000, 1);

    // Randomized run against the model.
    do_reset();
    model_reset();
    st = 20;
    mg = 2;
    md = 2'b11;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 31) == 0) begin
        st = int'($urandom_range(0, 255));
        mg = int'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
      sv = 1'($urandom_range(0, 1));
      for (int z = 0; z < NZ; z++) begin
        t = st + int'($urandom_range(0, 16)) - 8;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        temps[z*8 +: 8] = t[7:0];
      end
      drive(sv, temps, st, mg, md);
      model_step(sv, temps, st, mg, md);
      step();
      en = 0;
      for (int z = 0; z < NZ; z++) begin
        eh[z] = (ms[z] == MHeat);
        ec[z] = (ms[z] == MCool);
        er[z] = (ms[z] == MRest);
        if (eh[z] || ec[z]) en++;
      end
      check_outs($sformatf("rand%0d", cyc), eh, ec, er, en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
